// File: rtl/bus_mem_responder.sv
// Memory-side responder for the internal read/write bus: a RAM window at BASE_ADDR
// answering read_q/write_q after WAIT_CYCLES wait states with registered dn pulses.
//
// state   | meaning
// IDLE    | sampling requests; capture on a window hit
// WAIT    | counting wait states, frozen while rw_halt_in is high
// RESP    | dn pulse, echoed address and read data are on the bus
// RELEASE | waiting for the initiator to drop both requests
module bus_mem_responder #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_LOG2  = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_q,
  input  logic              write_q,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rw_halt_in,
  output logic              read_dn,
  output logic              write_dn,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              bus_busy
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_W-1:0]     lat_addr;
  logic [DATA_W-1:0]     lat_data;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic                  lat_write;
  logic [ADDR_W-1:0]     offset;
  logic                  hit;
  logic                  go_resp;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Below-base addresses wrap to a large offset and therefore miss.
  assign offset  = addr_in - BASE_ADDR;
  assign hit     = (offset >> DEPTH_LOG2) == '0;
  assign go_resp = (state == S_WAIT) && !rw_halt_in && (cnt == '0);

  // Reset forces IDLE, so a write caught mid-WAIT never reaches this port.
  always_ff @(posedge clk) begin
    if (go_resp && lat_write) mem[lat_idx] <= lat_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      read_dn   <= 1'b0;
      write_dn  <= 1'b0;
      addr_out  <= '0;
      data_out  <= '0;
      bus_busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((read_q || write_q) && hit) begin
            lat_addr  <= addr_in;
            lat_data  <= data_in;
            lat_idx   <= offset[DEPTH_LOG2-1:0];
            lat_write <= write_q;
            cnt       <= CNT_INIT;
            bus_busy  <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!rw_halt_in) begin
            if (cnt == '0) begin
              addr_out <= lat_addr;
              if (lat_write) begin
                write_dn <= 1'b1;
                data_out <= '0;
              end else begin
                read_dn  <= 1'b1;
                data_out <= mem[lat_idx];
              end
              state <= S_RESP;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        S_RESP: begin
          read_dn  <= 1'b0;
          write_dn <= 1'b0;
          addr_out <= '0;
          data_out <= '0;
          state    <= S_RELEASE;
        end
        S_RELEASE: begin
          if (!read_q && !write_q) begin
            bus_busy <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: a vector table of single transactions
// plus hand sequences for held requests, halted wait states and reset mid-transaction.
module tb_bus_mem_responder;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 10;
  localparam logic [31:0] BASE   = 32'h0000_0400;
  localparam int          WAITS  = 2;
  localparam int          LAT    = WAITS + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read_q = 1'b0;
  logic              write_q = 1'b0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic              rw_halt_in = 1'b0;
  logic              read_dn;
  logic              write_dn;
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] data_out;
  logic              bus_busy;

  bus_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH),
    .BASE_ADDR(BASE), .WAIT_CYCLES(WAITS)
  ) dut (
    .clk(clk), .rst(rst), .read_q(read_q), .write_q(write_q),
    .addr_in(addr_in), .data_in(data_in), .rw_halt_in(rw_halt_in),
    .read_dn(read_dn), .write_dn(write_dn), .addr_out(addr_out),
    .data_out(data_out), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hit;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives one request at a negedge and observes 40 cycles; q drops hold_extra
  // cycles after dn is seen, halt is high for halt_len cycles after halt_at.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input int halt_at, input int halt_len,
                     input int hold_extra, output int lat, output int n_rd,
                     output int n_wr, output logic [31:0] aout, output logic [31:0] dout,
                     output int busy_fall, output int busy_seen, output int bad);
    int   drop_at;
    logic prev_busy;
    lat = -1; n_rd = 0; n_wr = 0; aout = '0; dout = '0;
    busy_fall = -1; busy_seen = 0; bad = 0; drop_at = -1; prev_busy = 1'b0;
    @(negedge clk);
    read_q = rd; write_q = wr; addr_in = a; data_in = d;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (read_dn) n_rd++;
      if (write_dn) n_wr++;
      if (read_dn && write_dn) bad++;
      if (!(read_dn || write_dn) && addr_out != '0) bad++;
      if (!read_dn && data_out != '0) bad++;
      if (bus_busy) busy_seen++;
      if (prev_busy && !bus_busy && busy_fall < 0) busy_fall = cyc;
      prev_busy = bus_busy;
      if ((read_dn || write_dn) && lat < 0) begin
        lat = cyc; aout = addr_out; dout = data_out; drop_at = cyc + hold_extra;
      end
      if (cyc == drop_at) begin
        read_q = 1'b0; write_q = 1'b0;
      end
      rw_halt_in = (cyc >= halt_at && cyc < halt_at + halt_len);
    end
    read_q = 1'b0; write_q = 1'b0; rw_halt_in = 1'b0;
  endtask

  int          lat, n_rd, n_wr, busy_fall, busy_seen, bad;
  logic [31:0] aout, dout;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, BASE + 32'd5,    32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, BASE + 32'd5,    32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 1'b1, BASE,            32'hA5A5_0001, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, BASE + 32'h3FF,  32'h0BAD_F00D, 1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, BASE,            32'h0,         1'b1, 32'hA5A5_0001};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'h3FF,  32'h0,         1'b1, 32'h0BAD_F00D};
    vecs[6]  = '{1'b1, 1'b0, BASE - 32'd1,    32'h0,         1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, BASE + 32'h400,  32'hFFFF_0000, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0,           32'h0000_0077, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, BASE,            32'h0,         1'b1, 32'hA5A5_0001};
    vecs[10] = '{1'b1, 1'b1, BASE + 32'h10,   32'h0000_1234, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b0, BASE + 32'h10,   32'h0,         1'b1, 32'h0000_1234};
    vecs[12] = '{1'b0, 1'b1, BASE + 32'h20,   32'h0000_1111, 1'b1, 32'h0};

    #2;
    check("reset_outputs", {27'd0, read_dn, write_dn, bus_busy, |addr_out, |data_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 100, 0, 0,
          lat, n_rd, n_wr, aout, dout, busy_fall, busy_seen, bad);
      check($sformatf("v%0d_stray_outputs", i), bad, 0);
      if (vecs[i].hit) begin
        check($sformatf("v%0d_latency", i), lat, LAT);
        check($sformatf("v%0d_write_dn_count", i), n_wr, {31'd0, vecs[i].wr});
        check($sformatf("v%0d_read_dn_count", i), n_rd, {31'd0, !vecs[i].wr});
        check($sformatf("v%0d_addr_out", i), aout, vecs[i].addr);
        check($sformatf("v%0d_data_out", i), dout, vecs[i].exp_data);
        check($sformatf("v%0d_busy_fall", i), busy_fall, LAT + 2);
      end else begin
        check($sformatf("v%0d_miss_dn", i), n_rd + n_wr, 0);
        check($sformatf("v%0d_miss_busy", i), busy_seen, 0);
      end
    end

    // read_q held 10 cycles past read_dn: one pulse, busy drops the edge after release
    txn(1'b1, 1'b0, BASE + 32'd5, 32'h0, 100, 0, 10,
        lat, n_rd, n_wr, aout, dout, busy_fall, busy_seen, bad);
    check("hold_read_dn_count", n_rd, 1);
    check("hold_write_dn_count", n_wr, 0);
    check("hold_data_out", dout, 32'hDEAD_BEEF);
    check("hold_busy_fall", busy_fall, LAT + 11);
    check("hold_stray_outputs", bad, 0);

    // four halted cycles in WAIT stretch the latency by four
    txn(1'b0, 1'b1, BASE + 32'h30, 32'h0000_CAFE, 1, 4, 0,
        lat, n_rd, n_wr, aout, dout, busy_fall, busy_seen, bad);
    check("halt_latency", lat, LAT + 4);
    check("halt_write_dn_count", n_wr, 1);
    check("halt_addr_out", aout, BASE + 32'h30);
    txn(1'b1, 1'b0, BASE + 32'h30, 32'h0, 100, 0, 0,
        lat, n_rd, n_wr, aout, dout, busy_fall, busy_seen, bad);
    check("halt_readback", dout, 32'h0000_CAFE);

    // reset in the middle of WAIT discards the pending write
    @(negedge clk);
    write_q = 1'b1; addr_in = BASE + 32'h20; data_in = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'd0, bus_busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midwait_reset_outputs", {27'd0, read_dn, write_dn, bus_busy, |addr_out, |data_out}, 32'd0);
    write_q = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    txn(1'b1, 1'b0, BASE + 32'h20, 32'h0, 100, 0, 0,
        lat, n_rd, n_wr, aout, dout, busy_fall, busy_seen, bad);
    check("post_reset_latency", lat, LAT);
    check("post_reset_read_data", dout, 32'h0000_1111);
    check("post_reset_stray_outputs", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
